// File: rtl/synmul_sched_if.sv
// rtl/synmul_sched_if.sv - requester/response bundle for the shared multiplier scheduler
interface synmul_sched_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    req_neg;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [63:0]        rsp_product;
    logic               busy;
    logic [3:0]         inflight;

    modport master (
        output req_valid, req_a, req_b, req_neg, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product, busy, inflight
    );

    modport slave (
        input  req_valid, req_a, req_b, req_neg, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product, busy, inflight
    );
endinterface

// File: rtl/synmul_sched.sv
// rtl/synmul_sched.sv - round-robin scheduler around one pipelined 32x32 multiplier
// Optional result negation is enabled by defining SYNMUL_SCHED_NEGATE_EN.
module synmul_sched #(
    parameter int NREQ   = 2,
    parameter int STAGES = 4,
    parameter int IDW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    synmul_sched_if.slave bus
);
    logic [STAGES-1:0] vld_q, vld_d;
    logic [IDW-1:0]    tag_q  [STAGES];
    logic [IDW-1:0]    tag_d  [STAGES];
    logic [63:0]       data_q [STAGES];
    logic [63:0]       data_d [STAGES];
    logic [IDW-1:0]    rr_q, rr_d;

    logic              advance;
    logic              found;
    logic              accept;
    logic [IDW-1:0]    winner;
    logic [NREQ-1:0]   ready_c;
    logic [31:0]       sel_a, sel_b;
    logic [63:0]       prod;
    logic [63:0]       s2_data;
    logic [3:0]        inflight_c;

`ifdef SYNMUL_SCHED_NEGATE_EN
    logic neg_q, neg_d, sel_neg;
`else
    logic unused_neg;
    assign unused_neg = ^bus.req_neg;
`endif

    assign advance = !vld_q[STAGES-1] || bus.rsp_ready;

    // First pass picks the lowest valid index overall (wrap case); the second
    // overrides it with the lowest valid index at or above the pointer.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                found  = 1'b1;
                winner = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (IDW'(i) >= rr_q)) begin
                winner = IDW'(i);
            end
        end
    end

    assign accept = found && advance;

    always_comb begin
        ready_c = '0;
        sel_a   = '0;
        sel_b   = '0;
`ifdef SYNMUL_SCHED_NEGATE_EN
        sel_neg = 1'b0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                ready_c[i] = accept;
                sel_a      = bus.req_a[32*i +: 32];
                sel_b      = bus.req_b[32*i +: 32];
`ifdef SYNMUL_SCHED_NEGATE_EN
                sel_neg    = bus.req_neg[i];
`endif
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
        end
    end

    // s1 holds the raw operands {A,B}; the product is formed on the way into s2.
    assign prod = {32'h0, data_q[0][63:32]} * {32'h0, data_q[0][31:0]};
`ifdef SYNMUL_SCHED_NEGATE_EN
    assign s2_data = neg_q ? (~prod + 64'd1) : prod;
`else
    assign s2_data = prod;
`endif

    always_comb begin
        vld_d  = vld_q;
        tag_d  = tag_q;
        data_d = data_q;
`ifdef SYNMUL_SCHED_NEGATE_EN
        neg_d  = neg_q;
`endif
        if (advance) begin
            vld_d[0] = accept;
            if (accept) begin
                tag_d[0]  = winner;
                data_d[0] = {sel_a, sel_b};
`ifdef SYNMUL_SCHED_NEGATE_EN
                neg_d     = sel_neg;
`endif
            end
            // Bubbles clear only the valid bit so idle data lanes do not toggle.
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    tag_d[k]  = tag_q[k-1];
                    data_d[k] = (k == 1) ? s2_data : data_q[k-1];
                end
            end
        end
    end

    always_comb begin
        inflight_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            inflight_c = inflight_c + {3'b000, vld_q[k]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            rr_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                tag_q[k]  <= '0;
                data_q[k] <= '0;
            end
`ifdef SYNMUL_SCHED_NEGATE_EN
            neg_q <= 1'b0;
`endif
        end else begin
            vld_q <= vld_d;
            rr_q  <= rr_d;
            for (int k = 0; k < STAGES; k++) begin
                tag_q[k]  <= tag_d[k];
                data_q[k] <= data_d[k];
            end
`ifdef SYNMUL_SCHED_NEGATE_EN
            neg_q <= neg_d;
`endif
        end
    end

    assign bus.req_ready   = ready_c;
    assign bus.rsp_valid   = vld_q[STAGES-1];
    assign bus.rsp_id      = tag_q[STAGES-1];
    assign bus.rsp_product = data_q[STAGES-1];
    assign bus.busy        = |vld_q;
    assign bus.inflight    = inflight_c;
endmodule

// File: tb/tb_synmul_sched.sv
// tb/tb_synmul_sched.sv - scoreboard bench for the shared multiplier scheduler
module tb_synmul_sched;
    localparam int NREQ   = 2;
    localparam int STAGES = 4;
    localparam int IDW    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    synmul_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    synmul_sched #(.NREQ(NREQ), .STAGES(STAGES), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [63:0]    p;
    } exp_t;

    exp_t              q[$];
    int                vecs = 0;
    int                errs = 0;
    logic [STAGES-1:0] vm;
    logic [IDW-1:0]    rr_m;
    logic [NREQ-1:0]   last_acc;

    function automatic logic [63:0] model_prod(logic [31:0] a, logic [31:0] b, logic n);
        logic [63:0] p;
        logic        unused_n;
        p = 64'(a) * 64'(b);
        unused_n = n;
`ifdef SYNMUL_SCHED_NEGATE_EN
        if (n) p = 64'd0 - p;
`endif
        return p;
    endfunction

    // Independent model: arbiter pointer, stage-valid shift register, expected results.
    logic              m_adv, m_found;
    int                m_w, m_c;
    logic [NREQ-1:0]   m_rdy;
    exp_t              m_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            vm = '0;
            rr_m = '0;
            q.delete();
            last_acc = '0;
        end else begin
            vecs++;
            if (bus.rsp_valid !== vm[STAGES-1] || bus.busy !== (|vm) || bus.inflight !== 4'($countones(vm)))
                begin errs++; $display("FAIL occupancy: valid=%b busy=%b inflight=%0d, expected valid=%b busy=%b inflight=%0d",
                    bus.rsp_valid, bus.busy, bus.inflight, vm[STAGES-1], |vm, $countones(vm)); end
            m_adv = !vm[STAGES-1] || bus.rsp_ready;
            m_found = 1'b0;
            m_w = 0;
            for (int k = 0; k < NREQ; k++) begin
                m_c = (int'(rr_m) + k) % NREQ;
                if (!m_found && bus.req_valid[m_c]) begin m_found = 1'b1; m_w = m_c; end
            end
            m_rdy = '0;
            if (m_found && m_adv) m_rdy[m_w] = 1'b1;
            vecs++;
            if (bus.req_ready !== m_rdy) begin
                errs++; $display("FAIL req_ready: got %b expected %b", bus.req_ready, m_rdy);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                vecs++;
                if (q.size() == 0) begin
                    errs++; $display("FAIL unexpected_rsp: got id=%0d product=%h expected no response", bus.rsp_id, bus.rsp_product);
                end else begin
                    m_e = q.pop_front();
                    if (bus.rsp_id !== m_e.id || bus.rsp_product !== m_e.p) begin
                        errs++; $display("FAIL rsp: got id=%0d product=%h expected id=%0d product=%h",
                            bus.rsp_id, bus.rsp_product, m_e.id, m_e.p);
                    end
                end
            end
            last_acc = bus.req_valid & bus.req_ready;
            if (m_found && m_adv) begin
                q.push_back({IDW'(m_w), model_prod(bus.req_a[32*m_w +: 32], bus.req_b[32*m_w +: 32], bus.req_neg[m_w])});
                rr_m = IDW'((m_w + 1) % NREQ);
            end
            if (m_adv) vm = {vm[STAGES-2:0], m_found && m_adv};
        end
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic n);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_neg[i]        = n;
    endtask

    task automatic refresh_ops();
        for (int i = 0; i < NREQ; i++)
            if (last_acc[i]) set_op(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    task automatic wait_valid(output int cyc, output logic ok);
        ok = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin ok = 1'b1; cyc = c; break; end
        end
    endtask

    task automatic wait_drain(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_neg = '0; bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        vecs++;
        if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_product !== 64'd0 ||
            bus.busy !== 1'b0 || bus.inflight !== 4'd0) begin
            errs++; $display("FAIL reset_state: ready=%b valid=%b id=%0d product=%h busy=%b inflight=%0d expected all zero",
                bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_product, bus.busy, bus.inflight);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single(input logic [31:0] a, input logic [31:0] b, input logic n, input logic [63:0] want, input string nm);
        int lat, pulses;
        logic ok;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        set_op(0, a, b, n);
        bus.req_valid = 2'b01;
        @(negedge clk);
        vecs++;
        if (bus.req_ready !== 2'b01) begin errs++; $display("FAIL %s_ready: got %b expected 01", nm, bus.req_ready); end
        @(posedge clk); #1 bus.req_valid = '0; bus.req_neg = '0;
        wait_valid(lat, ok);
        vecs++;
        if (!ok || lat != STAGES) begin errs++; $display("FAIL %s_latency: got %0d (seen=%b) expected %0d", nm, lat, ok, STAGES); end
        vecs++;
        if (bus.rsp_id !== '0 || bus.rsp_product !== want) begin
            errs++; $display("FAIL %s_result: got id=%0d product=%h expected id=0 product=%h", nm, bus.rsp_id, bus.rsp_product, want);
        end
        pulses = 0;
        repeat (6) begin @(negedge clk); if (bus.rsp_valid) pulses++; end
        vecs++;
        if (pulses != 0) begin errs++; $display("FAIL %s_pulse: got %0d extra valid cycles expected 0", nm, pulses); end
    endtask

    task automatic test_back_to_back();
        int g[8];
        logic ok;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        set_op(0, $urandom, $urandom, 1'b0);
        set_op(1, $urandom, $urandom, 1'b1);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vecs++;
            if ($countones(bus.req_ready) != 1) begin
                errs++; $display("FAIL b2b_onehot: cycle %0d got ready=%b expected one grant", k, bus.req_ready);
            end
            g[k] = bus.req_ready[1] ? 1 : 0;
            @(posedge clk); #1 refresh_ops();
        end
        bus.req_valid = '0;
        for (int k = 1; k < 8; k++) begin
            vecs++;
            if (g[k] == g[k-1]) begin errs++; $display("FAIL b2b_alternate: cycle %0d got grant %0d expected %0d", k, g[k], 1 - g[k-1]); end
        end
        wait_drain(ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL b2b_drain: got %0d pending expected 0", q.size()); end
    endtask

    task automatic test_stall();
        logic ok;
        logic [IDW-1:0] hid;
        logic [63:0] hp;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        set_op(0, $urandom, $urandom, 1'b0);
        set_op(1, $urandom, $urandom, 1'b0);
        bus.req_valid = 2'b11;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.inflight == 4'(STAGES)) begin ok = 1'b1; break; end
            @(posedge clk); #1 refresh_ops();
        end
        vecs++;
        if (!ok) begin errs++; $display("FAIL stall_fill: got inflight=%0d expected %0d", bus.inflight, STAGES); end
        hid = bus.rsp_id;
        hp  = bus.rsp_product;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            vecs++;
            if (bus.req_ready !== '0 || bus.inflight !== 4'(STAGES) || bus.rsp_id !== hid || bus.rsp_product !== hp) begin
                errs++; $display("FAIL stall_hold: got ready=%b inflight=%0d id=%0d product=%h expected 00 %0d %0d %h",
                    bus.req_ready, bus.inflight, bus.rsp_id, bus.rsp_product, STAGES, hid, hp);
            end
        end
        vecs++;
        if (q.size() != STAGES) begin errs++; $display("FAIL stall_pending: got %0d expected %0d", q.size(), STAGES); end
        @(posedge clk); #1 bus.req_valid = '0; bus.rsp_ready = 1'b1;
        wait_drain(ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL stall_drain: got %0d pending expected 0", q.size()); end
    endtask

    task automatic test_mid_reset();
        logic ok;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        set_op(0, $urandom, $urandom, 1'b0);
        set_op(1, $urandom, $urandom, 1'b0);
        bus.req_valid = 2'b11;
        repeat (3) begin @(posedge clk); #1 refresh_ops(); end
        bus.req_valid = '0;
        vecs++;
        if (bus.inflight !== 4'd3) begin errs++; $display("FAIL midrst_pre: got inflight=%0d expected 3", bus.inflight); end
        rst_n = 1'b0;
        #1;
        vecs++;
        if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.inflight !== 4'd0) begin
            errs++; $display("FAIL midrst_clear: got valid=%b busy=%b inflight=%0d expected 0 0 0", bus.rsp_valid, bus.busy, bus.inflight);
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        set_op(0, 32'd7, 32'd9, 1'b0);
        set_op(1, 32'd11, 32'd13, 1'b0);
        bus.req_valid = 2'b11;
        @(negedge clk);
        vecs++;
        if (bus.req_ready !== 2'b01) begin errs++; $display("FAIL midrst_rr: got ready=%b expected 01", bus.req_ready); end
        @(posedge clk); #1 bus.req_valid = '0;
        wait_drain(ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL midrst_drain: got %0d pending expected 0", q.size()); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, "single");
        test_single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "max");
        test_back_to_back();
        test_stall();
`ifdef SYNMUL_SCHED_NEGATE_EN
        test_single(32'd1, 32'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "negate");
`else
        test_single(32'd1, 32'd1, 1'b1, 64'h0000_0000_0000_0001, "negate");
`endif
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
